// File: rtl/alu_pipelined_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_pipelined_pkg
// Brief  : Shared width and result/flag record types for the pipelined ALU.
// Rev    : 1.0  initial release
// ============================================================================
package alu_pipelined_pkg;

   localparam int WIDTH = 32;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic of;
   } alu_flags_t;

   typedef struct packed {
      logic [WIDTH-1:0] result;
      alu_flags_t       flags;
   } alu_result_t;

endpackage
`default_nettype wire

// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module : alu_result_fifo
// Brief  : Synchronous FIFO of ALU results; head is read combinationally.
// Rev    : 1.0  initial release
// ============================================================================
module alu_result_fifo
   import alu_pipelined_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic          pop_i,
   input  alu_result_t   wdata_i,
   output alu_result_t   rdata_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   alu_result_t   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_rd;
   logic          w_wr;

   assign empty_o = (r_count == '0);
   assign full_o  = (r_count == CW'(DEPTH));
   assign w_rd    = pop_i & ~empty_o;
   // At full a write is only accepted when the head leaves in the same cycle.
   assign w_wr    = push_i & (~full_o | w_rd);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_wr) begin
            r_mem[r_wr_ptr] <= wdata_i;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_wr && !w_rd) begin
            r_count <= r_count + CW'(1);
         end else if (w_rd && !w_wr) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   assign rdata_o = r_mem[r_rd_ptr];
   assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/alu_result_collector.sv
`default_nettype none
// ============================================================================
// Module : alu_result_collector
// Brief  : Credit-controlled collector buffering ALU results for a
//          valid/ready consumer, with sticky protocol error flag.
// Rev    : 1.0  initial release
// ============================================================================
module alu_result_collector
   import alu_pipelined_pkg::*;
#(
   parameter  int WIDTH = alu_pipelined_pkg::WIDTH,
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             issue_i,
   output logic             credit_ok_o,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_result_i,
   input  logic [3:0]       in_flags_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_result_o,
   output logic [3:0]       out_flags_o,
   output logic [CW-1:0]    count_o,
   output logic             err_o
);

   alu_result_t   w_wdata;
   alu_result_t   w_rdata;
   logic [CW-1:0] w_count;
   logic [CW-1:0] r_inflight;
   logic [CW:0]   w_committed;
   logic          r_err;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic          w_credit_ok;
   logic          w_overissue;
   logic          w_unsolicited;
   logic          w_drop;

   assign w_wdata = {in_result_i, in_flags_i};
   assign w_push  = in_valid_i;
   assign w_pop   = ~w_empty & out_ready_i;

   alu_result_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .wdata_i (w_wdata),
      .rdata_o (w_rdata),
      .count_o (w_count),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   // Every stored or outstanding result owns a slot, so in-flight results never drop.
   assign w_committed = {1'b0, w_count} + {1'b0, r_inflight};
   assign w_credit_ok = (w_committed < (CW + 1)'(DEPTH));

   assign w_overissue   = issue_i & ~w_credit_ok;
   assign w_unsolicited = in_valid_i & ~issue_i & (r_inflight == '0);
   assign w_drop        = w_push & w_full & ~w_pop;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_inflight <= '0;
         r_err      <= 1'b0;
      end else begin
         if (issue_i && !in_valid_i) begin
            if (r_inflight != '1) begin
               r_inflight <= r_inflight + CW'(1);
            end
         end else if (!issue_i && in_valid_i && (r_inflight != '0)) begin
            r_inflight <= r_inflight - CW'(1);
         end
         r_err <= r_err | w_overissue | w_unsolicited | w_drop;
      end
   end

   assign credit_ok_o  = w_credit_ok;
   assign out_valid_o  = ~w_empty;
   assign out_result_o = w_rdata.result;
   assign out_flags_o  = w_rdata.flags;
   assign count_o      = w_count;
   assign err_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_collector.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_result_collector
// Brief  : Directed self-checking bench for alu_result_collector.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_result_collector;

   logic        clk;
   logic        rst_ni;
   logic        issue_i;
   logic        credit_ok_o;
   logic        in_valid_i;
   logic [31:0] in_result_i;
   logic [3:0]  in_flags_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_result_o;
   logic [3:0]  out_flags_o;
   logic [2:0]  count_o;
   logic        err_o;

   int tests_run = 0;
   int fails     = 0;

   alu_result_collector #(
      .WIDTH (32),
      .DEPTH (4)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .issue_i      (issue_i),
      .credit_ok_o  (credit_ok_o),
      .in_valid_i   (in_valid_i),
      .in_result_i  (in_result_i),
      .in_flags_i   (in_flags_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .out_result_o (out_result_o),
      .out_flags_o  (out_flags_o),
      .count_o      (count_o),
      .err_o        (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_ni      = 1'b0;
      issue_i     = 1'b0;
      in_valid_i  = 1'b0;
      in_result_i = '0;
      in_flags_i  = '0;
      out_ready_i = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic issue_n(input int n);
      for (int i = 0; i < n; i++) begin
         issue_i = 1'b1;
         tick();
      end
      issue_i = 1'b0;
   endtask

   // Returns n results: base+i with flags i+1.
   task automatic return_n(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         in_valid_i  = 1'b1;
         in_result_i = base + 32'(i);
         in_flags_i  = 4'(i + 1);
         tick();
      end
      in_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++; if (credit_ok_o !== 1'b1) begin fails++; $display("FAIL reset_credit: got %b expected 1", credit_ok_o); end
      tests_run++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", out_valid_o); end
      tests_run++; if (count_o !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count_o); end
      tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err_o); end
      tests_run++; if (out_result_o !== 32'd0) begin fails++; $display("FAIL reset_result: got %0h expected 0", out_result_o); end
   endtask

   task automatic test_single_op();
      issue_i = 1'b1;
      tick();
      issue_i = 1'b0;
      tick();
      in_valid_i  = 1'b1;
      in_result_i = 32'd8;
      in_flags_i  = 4'b0000;
      tick();
      in_valid_i = 1'b0;
      tests_run++; if (out_valid_o !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", out_valid_o); end
      tests_run++; if (out_result_o !== 32'd8) begin fails++; $display("FAIL single_result: got %0d expected 8", out_result_o); end
      tests_run++; if (out_flags_o !== 4'd0) begin fails++; $display("FAIL single_flags: got %b expected 0000", out_flags_o); end
      tests_run++; if (count_o !== 3'd1) begin fails++; $display("FAIL single_count: got %0d expected 1", count_o); end
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      tests_run++; if (count_o !== 3'd0) begin fails++; $display("FAIL single_pop_count: got %0d expected 0", count_o); end
      tests_run++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL single_pop_valid: got %b expected 0", out_valid_o); end
      tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL single_err: got %b expected 0", err_o); end
   endtask

   task automatic test_fill();
      out_ready_i = 1'b0;
      issue_n(3);
      tests_run++; if (credit_ok_o !== 1'b1) begin fails++; $display("FAIL fill_credit3: got %b expected 1", credit_ok_o); end
      issue_n(1);
      tests_run++; if (credit_ok_o !== 1'b0) begin fails++; $display("FAIL fill_credit4: got %b expected 0", credit_ok_o); end
      return_n(32'd100, 4);
      tests_run++; if (count_o !== 3'd4) begin fails++; $display("FAIL fill_count: got %0d expected 4", count_o); end
      for (int i = 0; i < 3; i++) begin
         tests_run++; if (out_result_o !== 32'd100 || out_flags_o !== 4'd1) begin fails++; $display("FAIL fill_hold: got %0d/%b expected 100/0001", out_result_o, out_flags_o); end
         tick();
      end
      tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL fill_err: got %b expected 0", err_o); end
      tests_run++; if (credit_ok_o !== 1'b0) begin fails++; $display("FAIL fill_credit_full: got %b expected 0", credit_ok_o); end
   endtask

   // With the FIFO full no credit can be outstanding, so this push is
   // unsolicited and flags err_o; the FIFO itself must still accept it.
   task automatic test_full_push_pop();
      logic [31:0] exp_q [4];
      exp_q[0] = 32'd101; exp_q[1] = 32'd102; exp_q[2] = 32'd103; exp_q[3] = 32'd200;
      in_valid_i  = 1'b1;
      in_result_i = 32'd200;
      in_flags_i  = 4'b1010;
      out_ready_i = 1'b1;
      tick();
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      tests_run++; if (count_o !== 3'd4) begin fails++; $display("FAIL fpp_count: got %0d expected 4", count_o); end
      tests_run++; if (err_o !== 1'b1) begin fails++; $display("FAIL fpp_err: got %b expected 1", err_o); end
      for (int i = 0; i < 4; i++) begin
         tests_run++; if (out_result_o !== exp_q[i]) begin fails++; $display("FAIL fpp_order%0d: got %0d expected %0d", i, out_result_o, exp_q[i]); end
         out_ready_i = 1'b1;
         tick();
      end
      out_ready_i = 1'b0;
      tests_run++; if (count_o !== 3'd0) begin fails++; $display("FAIL fpp_drain: got %0d expected 0", count_o); end
   endtask

   task automatic test_drop();
      do_reset();
      issue_n(4);
      return_n(32'd10, 4);
      tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL drop_pre_err: got %b expected 0", err_o); end
      in_valid_i  = 1'b1;
      in_result_i = 32'd99;
      in_flags_i  = 4'b1111;
      tick();
      in_valid_i = 1'b0;
      tests_run++; if (err_o !== 1'b1) begin fails++; $display("FAIL drop_err: got %b expected 1", err_o); end
      tests_run++; if (count_o !== 3'd4) begin fails++; $display("FAIL drop_count: got %0d expected 4", count_o); end
      tests_run++; if (out_result_o !== 32'd10) begin fails++; $display("FAIL drop_head: got %0d expected 10", out_result_o); end
      tick();
      tick();
      tests_run++; if (err_o !== 1'b1) begin fails++; $display("FAIL drop_sticky: got %b expected 1", err_o); end
      for (int i = 0; i < 4; i++) begin
         tests_run++; if (out_result_o !== 32'(10 + i)) begin fails++; $display("FAIL drop_order%0d: got %0d expected %0d", i, out_result_o, 10 + i); end
         out_ready_i = 1'b1;
         tick();
      end
      out_ready_i = 1'b0;
      tests_run++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL drop_no_stale: got %b expected 0", out_valid_o); end
   endtask

   task automatic test_unsolicited();
      do_reset();
      in_valid_i  = 1'b1;
      in_result_i = 32'd55;
      in_flags_i  = 4'b0100;
      tick();
      in_valid_i = 1'b0;
      tests_run++; if (err_o !== 1'b1) begin fails++; $display("FAIL unsol_err: got %b expected 1", err_o); end
      tests_run++; if (count_o !== 3'd1) begin fails++; $display("FAIL unsol_count: got %0d expected 1", count_o); end
      // count 1 + inflight 2 = 3 leaves a credit; a third issue exhausts it.
      issue_n(2);
      tests_run++; if (credit_ok_o !== 1'b1) begin fails++; $display("FAIL unsol_credit2: got %b expected 1", credit_ok_o); end
      issue_n(1);
      tests_run++; if (credit_ok_o !== 1'b0) begin fails++; $display("FAIL unsol_credit3: got %b expected 0", credit_ok_o); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      issue_n(4);
      return_n(32'd30, 3);
      tests_run++; if (count_o !== 3'd3) begin fails++; $display("FAIL mid_pre_count: got %0d expected 3", count_o); end
      #2;
      rst_ni = 1'b0;
      #1;
      tests_run++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b expected 0", out_valid_o); end
      tests_run++; if (count_o !== 3'd0) begin fails++; $display("FAIL mid_count: got %0d expected 0", count_o); end
      tests_run++; if (credit_ok_o !== 1'b1) begin fails++; $display("FAIL mid_credit: got %b expected 1", credit_ok_o); end
      tests_run++; if (out_result_o !== 32'd0 || out_flags_o !== 4'd0) begin fails++; $display("FAIL mid_data: got %0h/%b expected 0/0000", out_result_o, out_flags_o); end
      tick();
      rst_ni = 1'b1;
      tick();
      tick();
      tests_run++; if (out_valid_o !== 1'b0 || count_o !== 3'd0) begin fails++; $display("FAIL mid_stale: got valid %b count %0d expected 0/0", out_valid_o, count_o); end
      tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL mid_err: got %b expected 0", err_o); end
      issue_n(1);
      tick();
      return_n(32'd77, 1);
      tests_run++; if (out_result_o !== 32'd77 || count_o !== 3'd1) begin fails++; $display("FAIL mid_fresh: got %0d count %0d expected 77 count 1", out_result_o, count_o); end
      tests_run++; if (err_o !== 1'b0) begin fails++; $display("FAIL mid_fresh_err: got %b expected 0", err_o); end
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_fill();
      test_full_push_pop();
      test_drop();
      test_unsolicited();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
`default_nettype wire
